// File: rtl/hw_imp_arb_pkg.sv
// Shared types and default widths for the two-master hw_imp arbiter.
package hw_imp_arb_pkg;

  // Default bus widths: hw_imp has 32-bit data and a 1-bit word address.
  localparam int ARB_DATA_W = 32;
  localparam int ARB_ADDR_W = 1;

  // Arbiter FSM encoding; also exported on the debug state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_lock_timer.sv
// Lock watchdog counter: clears on request, otherwise counts up and
// saturates at LOCK_TIMEOUT-1, where it reports expiry.
module arb_lock_timer #(
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expire
);

  // LOCK_TIMEOUT is at least 2, so the counter is at least one bit wide.
  localparam int CNT_W = $clog2(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Idle-cycle counter: clear wins, then count up, holding at the limit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire = (cnt_q == CNT_MAX);

endmodule

// File: rtl/hw_imp_arbiter.sv
// Two-master Avalon-MM arbiter in front of the single hw_imp slave.
// Round-robin grant with an optional per-master lock and a lock watchdog.
//
// Handshake: a master's transfer completes in the cycle where it asserts
// read or write while holding the grant and its waitrequest is low. The
// granted master sees the slave's waitrequest directly; the other master
// (and both masters while IDLE) sees waitrequest=1. Requests are not
// buffered, so masters must keep address/data/control stable while stalled.
module hw_imp_arbiter
  import hw_imp_arb_pkg::*;
#(
  parameter int DATA_W       = ARB_DATA_W,
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              reset,
  // master 0
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_read,
  input  logic              m0_lock,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  // master 1
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_read,
  input  logic              m1_lock,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  // hw_imp slave
  output logic [ADDR_W-1:0] s_address,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic              s_read,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  // status
  output logic              timeout_flag,
  output arb_state_t        state_dbg
);

  arb_state_t state_q, state_d;
  // last_q names the master granted most recently (0 or 1); the other one
  // wins the next tie.
  logic last_q, last_d;
  logic flag_set;

  logic req0, req1;
  logic sel_lock, sel_active, sel_req, sel_xfer;
  logic wd_clear, wd_expire_raw, wd_expire;
  logic release_grant;

  // A held lock counts as a request so a locked master keeps its claim
  // between transfers.
  assign req0 = m0_write | m0_read | m0_lock;
  assign req1 = m1_write | m1_read | m1_lock;

  // Select the controls of whichever master holds the grant (zero in IDLE).
  always_comb begin
    sel_lock   = 1'b0;
    sel_active = 1'b0;
    sel_req    = 1'b0;
    case (state_q)
      GNT0: begin
        sel_lock   = m0_lock;
        sel_active = m0_write | m0_read;
        sel_req    = req0;
      end
      GNT1: begin
        sel_lock   = m1_lock;
        sel_active = m1_write | m1_read;
        sel_req    = req1;
      end
      default: ;
    endcase
  end

  assign sel_xfer = sel_active & ~s_waitrequest;

  // Held at zero in IDLE so every grant starts with a fresh count; any
  // read/write (even a stalled one) counts as activity.
  assign wd_clear = (state_q == IDLE) | sel_active;

  arb_lock_timer #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_lock_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .expire (wd_expire_raw)
  );

  // Forced release applies only to a locked grant sitting idle.
  assign wd_expire = wd_expire_raw & sel_lock & ~sel_active & (state_q != IDLE);

  // Grant ends after an unlocked transfer, on withdrawal, or on watchdog.
  assign release_grant = (sel_xfer & ~sel_lock) | ~sel_req | wd_expire;

  // Next-state, round-robin pointer and slave/master muxing.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    flag_set       = 1'b0;
    s_address      = '0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_read         = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state_q)
      IDLE: begin
        // On a tie, grant the master that was not granted last.
        if (req0 && (!req1 || last_q)) begin
          state_d = GNT0;
        end else if (req1) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        s_address      = m0_address;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_read         = m0_read;
        m0_waitrequest = s_waitrequest;
        if (release_grant) begin
          state_d  = IDLE;
          last_d   = 1'b0;
          flag_set = wd_expire;
        end
      end
      GNT1: begin
        s_address      = m1_address;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_read         = m1_read;
        m1_waitrequest = s_waitrequest;
        if (release_grant) begin
          state_d  = IDLE;
          last_d   = 1'b1;
          flag_set = wd_expire;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin pointer; m0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Sticky watchdog-release indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_flag <= 1'b0;
    end else if (flag_set) begin
      timeout_flag <= 1'b1;
    end
  end

  // Read data is broadcast; each master qualifies it with its own handshake.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hw_imp_arbiter.sv
// Bench for hw_imp_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of the arbitration rules.
module tb_hw_imp_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 1;
  localparam int LT     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address, s_address;
  logic              m0_write, m0_read, m0_lock, m0_waitrequest;
  logic              m1_write, m1_read, m1_lock, m1_waitrequest;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_readdata;
  logic              s_write, s_read, s_waitrequest, timeout_flag;
  hw_imp_arb_pkg::arb_state_t state_dbg;

  int errors = 0;
  int checks = 0;

  // reference model: owner (-1 none), last owner, quiet-cycle run, flag
  int mo, ml, mrun;
  bit mflag;

  hw_imp_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_read(m0_read), .m0_lock(m0_lock), .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_lock(m1_lock), .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
    .s_read(s_read), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .timeout_flag(timeout_flag), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // Inputs change just after a falling edge; outputs are sampled #1 later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_address = '0; m0_write = 1'b0; m0_writedata = '0; m0_read = 1'b0; m0_lock = 1'b0;
    m1_address = '0; m1_write = 1'b0; m1_writedata = '0; m1_read = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); s_waitrequest = 1'b0; s_readdata = '0;
    cyc(); cyc(); #1;
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
    checks++; if (s_write !== 1'b0 || s_read !== 1'b0) begin errors++; $display("FAIL reset_s_ctrl: got w=%b r=%b want 0 0", s_write, s_read); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b want 0", timeout_flag); end
    checks++; if (state_dbg !== hw_imp_arb_pkg::IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_single_write();
    m0_address = 1'b1; m0_write = 1'b1; m0_writedata = 32'h01234567; s_waitrequest = 1'b0;
    #1;
    checks++; if (m0_waitrequest !== 1'b1 || s_write !== 1'b0) begin errors++; $display("FAIL sw_arb_cycle: got wait=%b s_write=%b want 1 0", m0_waitrequest, s_write); end
    cyc(); #1;
    checks++; if (s_write !== 1'b1) begin errors++; $display("FAIL sw_s_write: got %b want 1", s_write); end
    checks++; if (s_writedata !== 32'h01234567) begin errors++; $display("FAIL sw_wdata: got %h want 01234567", s_writedata); end
    checks++; if (s_address !== 1'b1) begin errors++; $display("FAIL sw_addr: got %b want 1", s_address); end
    checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL sw_waits: got m0=%b m1=%b want 0 1", m0_waitrequest, m1_waitrequest); end
    cyc(); m0_write = 1'b0; #1;
    checks++; if (s_write !== 1'b0 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL sw_idle_after: got s_write=%b wait=%b want 0 1", s_write, m0_waitrequest); end
    cyc();
  endtask

  task automatic test_tie();
    reset = 1'b1; idle_inputs(); cyc(); reset = 1'b0;
    m0_write = 1'b1; m0_writedata = 32'hAAAA0001; m0_address = 1'b0;
    m1_write = 1'b1; m1_writedata = 32'hBBBB0001; m1_address = 1'b1;
    #1;
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_idle: got m0=%b m1=%b want 1 1", m0_waitrequest, m1_waitrequest); end
    cyc(); #1;
    checks++; if (s_writedata !== 32'hAAAA0001 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_first_m0: got wd=%h m0=%b m1=%b want aaaa0001 0 1", s_writedata, m0_waitrequest, m1_waitrequest); end
    cyc(); m0_write = 1'b0; #1;
    checks++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_bubble: got s_write=%b m1=%b want 0 1", s_write, m1_waitrequest); end
    cyc(); #1;
    checks++; if (s_writedata !== 32'hBBBB0001 || s_address !== 1'b1 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL tie_second_m1: got wd=%h a=%b m1=%b m0=%b want bbbb0001 1 0 1", s_writedata, s_address, m1_waitrequest, m0_waitrequest); end
    cyc();
    m0_write = 1'b1; m0_writedata = 32'hAAAA0002;
    m1_write = 1'b1; m1_writedata = 32'hBBBB0002;
    #1;
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL tie3_bubble: got s_write=%b want 0", s_write); end
    cyc(); #1;
    checks++; if (s_writedata !== 32'hAAAA0002 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL tie3_m0: got wd=%h m0=%b want aaaa0002 0", s_writedata, m0_waitrequest); end
    cyc(); m0_write = 1'b0;
    cyc(); #1;
    checks++; if (s_writedata !== 32'hBBBB0002 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL tie3_m1: got wd=%h m1=%b want bbbb0002 0", s_writedata, m1_waitrequest); end
    cyc(); m1_write = 1'b0;
    cyc();
  endtask

  task automatic test_locked_job();
    m0_lock = 1'b1; m0_write = 1'b1; m0_address = 1'b0; m0_writedata = 32'd1; s_waitrequest = 1'b0;
    cyc();
    m1_write = 1'b1; m1_writedata = 32'h0000BEEF; m1_address = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      m0_writedata = 32'(k);
      #1;
      checks++; if (s_write !== 1'b1 || s_writedata !== 32'(k) || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL job_write%0d: got w=%b wd=%h m0=%b m1=%b want 1 %h 0 1", k, s_write, s_writedata, m0_waitrequest, m1_waitrequest, k); end
      cyc();
    end
    m0_write = 1'b0; m0_read = 1'b1; s_readdata = 32'h00ABCDEF;
    #1;
    checks++; if (s_read !== 1'b1 || s_write !== 1'b0 || m0_waitrequest !== 1'b0) begin errors++; $display("FAIL job_read_ctrl: got r=%b w=%b m0=%b want 1 0 0", s_read, s_write, m0_waitrequest); end
    checks++; if (m0_readdata !== 32'h00ABCDEF) begin errors++; $display("FAIL job_readdata: got %h want 00abcdef", m0_readdata); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL job_m1_held: got %b want 1", m1_waitrequest); end
    cyc(); m0_read = 1'b0; m0_lock = 1'b0; #1;
    checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL job_still_locked: got m0=%b m1=%b want 0 1", m0_waitrequest, m1_waitrequest); end
    cyc(); #1;
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL job_bubble: got m0=%b m1=%b want 1 1", m0_waitrequest, m1_waitrequest); end
    cyc(); #1;
    checks++; if (s_writedata !== 32'h0000BEEF || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL job_m1_granted: got wd=%h m1=%b want 0000beef 0", s_writedata, m1_waitrequest); end
    cyc(); m1_write = 1'b0;
    cyc();
  endtask

  task automatic test_stall();
    m1_write = 1'b1; m1_lock = 1'b1; m1_writedata = 32'h5A5A0001; m1_address = 1'b0; s_waitrequest = 1'b1;
    cyc();
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if (m1_waitrequest !== 1'b1 || s_write !== 1'b1 || s_writedata !== 32'h5A5A0001 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL stall_%0d: got m1=%b w=%b wd=%h m0=%b want 1 1 5a5a0001 1", k, m1_waitrequest, s_write, s_writedata, m0_waitrequest); end
      cyc();
    end
    s_waitrequest = 1'b0; m1_lock = 1'b0; #1;
    checks++; if (m1_waitrequest !== 1'b0 || s_write !== 1'b1 || timeout_flag !== 1'b0) begin errors++; $display("FAIL stall_accept: got m1=%b w=%b flag=%b want 0 1 0", m1_waitrequest, s_write, timeout_flag); end
    cyc(); m1_write = 1'b0; #1;
    checks++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1 || timeout_flag !== 1'b0) begin errors++; $display("FAIL stall_release: got w=%b m1=%b flag=%b want 0 1 0", s_write, m1_waitrequest, timeout_flag); end
    cyc();
  endtask

  task automatic test_watchdog();
    m0_lock = 1'b1; s_waitrequest = 1'b0;
    cyc();
    m1_write = 1'b1; m1_writedata = 32'h00C0FFEE; m1_address = 1'b1;
    for (int k = 0; k < LT; k++) begin
      #1;
      checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || timeout_flag !== 1'b0) begin errors++; $display("FAIL wd_hold_%0d: got m0=%b m1=%b flag=%b want 0 1 0", k, m0_waitrequest, m1_waitrequest, timeout_flag); end
      cyc();
    end
    #1;
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || timeout_flag !== 1'b1) begin errors++; $display("FAIL wd_release: got m0=%b m1=%b flag=%b want 1 1 1", m0_waitrequest, m1_waitrequest, timeout_flag); end
    cyc(); #1;
    checks++; if (m1_waitrequest !== 1'b0 || s_writedata !== 32'h00C0FFEE || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL wd_m1_next: got m1=%b wd=%h m0=%b want 0 00c0ffee 1", m1_waitrequest, s_writedata, m0_waitrequest); end
    cyc(); m1_write = 1'b0; m0_lock = 1'b0; #1;
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b want 1", timeout_flag); end
    cyc();
  endtask

  task automatic test_reset_mid();
    m0_write = 1'b1; m0_writedata = 32'hDEADBEEF; m0_address = 1'b0; s_waitrequest = 1'b1;
    cyc(); #1;
    checks++; if (s_write !== 1'b1 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_granted: got w=%b m0=%b want 1 1", s_write, m0_waitrequest); end
    reset = 1'b1;
    cyc(); #1;
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || s_write !== 1'b0) begin errors++; $display("FAIL rm_dropped: got m0=%b m1=%b w=%b want 1 1 0", m0_waitrequest, m1_waitrequest, s_write); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL rm_flag: got %b want 0", timeout_flag); end
    checks++; if (state_dbg !== hw_imp_arb_pkg::IDLE) begin errors++; $display("FAIL rm_state: got %0d want 0", state_dbg); end
    reset = 1'b0; m0_write = 1'b0; s_waitrequest = 1'b0;
    cyc();
  endtask

  task automatic test_random(input int n);
    bit p0, p1, d0, d1, r0, r1, act, lk, rq;
    logic ew0, ew1, ewr, erd;
    reset = 1'b1; idle_inputs(); cyc(); reset = 1'b0;
    mo = -1; ml = 1; mrun = 0; mflag = 1'b0;
    p0 = 1'b0; p1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
    for (int c = 0; c < n; c++) begin
      // retire completed operations, then maybe start new ones
      if (d0) begin p0 = 1'b0; m0_write = 1'b0; m0_read = 1'b0; end
      if (d1) begin p1 = 1'b0; m1_write = 1'b0; m1_read = 1'b0; end
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; r0 = ($urandom_range(0, 1) == 1);
        m0_write = r0; m0_read = !r0;
        m0_address = ADDR_W'($urandom_range(0, 1)); m0_writedata = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; r1 = ($urandom_range(0, 1) == 1);
        m1_write = r1; m1_read = !r1;
        m1_address = ADDR_W'($urandom_range(0, 1)); m1_writedata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) m0_lock = !m0_lock;
      if ($urandom_range(0, 7) == 0) m1_lock = !m1_lock;
      s_waitrequest = ($urandom_range(0, 3) == 0);
      s_readdata = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      #1;
      // expected outputs from the model's current owner
      ew0 = 1'b1; ew1 = 1'b1; ewr = 1'b0; erd = 1'b0;
      if (mo == 0) begin ew0 = s_waitrequest; ewr = m0_write; erd = m0_read; end
      else if (mo == 1) begin ew1 = s_waitrequest; ewr = m1_write; erd = m1_read; end
      checks++; if (m0_waitrequest !== ew0) begin errors++; $display("FAIL rnd_m0_wait c=%0d: got %b want %b", c, m0_waitrequest, ew0); end
      checks++; if (m1_waitrequest !== ew1) begin errors++; $display("FAIL rnd_m1_wait c=%0d: got %b want %b", c, m1_waitrequest, ew1); end
      checks++; if (s_write !== ewr || s_read !== erd) begin errors++; $display("FAIL rnd_s_ctrl c=%0d: got w=%b r=%b want %b %b", c, s_write, s_read, ewr, erd); end
      checks++; if (timeout_flag !== mflag) begin errors++; $display("FAIL rnd_flag c=%0d: got %b want %b", c, timeout_flag, mflag); end
      checks++; if (m0_readdata !== s_readdata || m1_readdata !== s_readdata) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h %h want %h", c, m0_readdata, m1_readdata, s_readdata); end
      if (mo == 0) begin
        checks++; if (s_address !== m0_address || s_writedata !== m0_writedata) begin errors++; $display("FAIL rnd_pass0 c=%0d: got a=%b wd=%h want %b %h", c, s_address, s_writedata, m0_address, m0_writedata); end
      end else if (mo == 1) begin
        checks++; if (s_address !== m1_address || s_writedata !== m1_writedata) begin errors++; $display("FAIL rnd_pass1 c=%0d: got a=%b wd=%h want %b %h", c, s_address, s_writedata, m1_address, m1_writedata); end
      end
      // which masters finish an operation at this edge
      d0 = reset || (p0 && mo == 0 && !s_waitrequest);
      d1 = reset || (p1 && mo == 1 && !s_waitrequest);
      // advance the model across the coming edge
      if (reset) begin
        mo = -1; ml = 1; mrun = 0; mflag = 1'b0;
      end else if (mo < 0) begin
        r0 = m0_write | m0_read | m0_lock;
        r1 = m1_write | m1_read | m1_lock;
        if (r0 && r1) mo = (ml == 0) ? 1 : 0;
        else if (r0) mo = 0;
        else if (r1) mo = 1;
        mrun = 0;
      end else begin
        act = (mo == 0) ? (m0_write | m0_read) : (m1_write | m1_read);
        lk  = (mo == 0) ? m0_lock : m1_lock;
        rq  = act | lk;
        if (act) mrun = 0; else mrun++;
        if (act && !s_waitrequest && !lk) begin ml = mo; mo = -1; end
        else if (!rq) begin ml = mo; mo = -1; end
        else if (lk && mrun >= LT) begin ml = mo; mo = -1; mflag = 1'b1; end
      end
      cyc();
    end
    reset = 1'b0; idle_inputs();
    cyc();
  endtask

  // bounded run time
  initial begin
    #500000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_locked_job();
    test_stall();
    test_watchdog();
    test_reset_mid();
    test_random(3000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
